// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// Issue/hazard controller between decode and ID/EX: a destination-register scoreboard
// stalls decode only on read-after-write hazards and can bypass the RF-writing stage.
module pipe_hazard_ctrl #(
   parameter int STAGES_P    = 3,
   parameter int RF_ADDR_W_P = 6,
   parameter int BYPASS_P    = 0,
   parameter int FIXED_NOP_P = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        issue_valid_i,
   input  logic [RF_ADDR_W_P-1:0]      rs_addr_i,
   input  logic [RF_ADDR_W_P-1:0]      rd_addr_i,
   input  logic                        rs_used_i,
   input  logic                        rd_used_i,
   input  logic                        writes_rf_i,
   input  logic [RF_ADDR_W_P-1:0]      wa_i,
   input  logic                        is_load_i,
   input  logic                        hold_i,
   input  logic                        flush_i,
   output logic                        bubble_o,
   output logic                        issue_o,
   output logic                        fwd_rs_o,
   output logic                        fwd_rd_o,
   output logic [$clog2(STAGES_P)-1:0] inflight_cnt_o,
   output logic [31:0]                 nop_count_o
);

   localparam int D      = STAGES_P - 2;
   localparam int IW     = $clog2(STAGES_P);
   localparam int CW     = (FIXED_NOP_P > 0) ? $clog2(FIXED_NOP_P + 1) : 1;
   localparam bit FIXED  = (FIXED_NOP_P > 0);
   localparam bit BYPASS = (BYPASS_P != 0);

   // Entry k holds the instruction k cycles past decode; entry D writes the RF this cycle.
   logic [D:1]             sb_valid;
   logic [D:1]             sb_load;
   logic [RF_ADDR_W_P-1:0] sb_wa [1:D];
   logic [CW-1:0]          cnt;

   logic [D:1]             nxt_valid;
   logic [D:1]             nxt_load;
   logic [RF_ADDR_W_P-1:0] nxt_wa [1:D];
   logic [IW-1:0]          nxt_inflight;
   logic [CW-1:0]          nxt_cnt;
   logic [31:0]            nxt_nop;

   logic [D:1] match_rs;
   logic [D:1] match_rd;
   logic       near_rs;
   logic       near_rd;
   logic       late_ok;
   logic       haz_rs;
   logic       haz_rd;
   logic       hazard;

   always_comb begin
      match_rs = '0;
      match_rd = '0;
      near_rs  = 1'b0;
      near_rd  = 1'b0;
      for (int k = 1; k <= D; k++) begin
         match_rs[k] = sb_valid[k] & (sb_wa[k] == rs_addr_i) & rs_used_i;
         match_rd[k] = sb_valid[k] & (sb_wa[k] == rd_addr_i) & rd_used_i;
      end
      for (int k = 1; k < D; k++) begin
         near_rs = near_rs | match_rs[k];
         near_rd = near_rd | match_rd[k];
      end
   end

   // A match in the RF-writing stage is harmless only when it can be bypassed.
   assign late_ok = BYPASS & ~sb_load[D];
   assign haz_rs  = near_rs | (match_rs[D] & ~late_ok);
   assign haz_rd  = near_rd | (match_rd[D] & ~late_ok);
   assign hazard  = haz_rs | haz_rd;

   assign fwd_rs_o = ~FIXED & late_ok & match_rs[D] & ~near_rs;
   assign fwd_rd_o = ~FIXED & late_ok & match_rd[D] & ~near_rd;
   assign bubble_o = FIXED ? (cnt != '0) : (issue_valid_i & hazard);
   assign issue_o  = issue_valid_i & ~bubble_o & ~hold_i & ~flush_i;

   always_comb begin
      nxt_valid = sb_valid;
      nxt_load  = sb_load;
      nxt_wa    = sb_wa;
      if (flush_i) begin
         nxt_valid = '0;
      end else begin
         for (int k = D; k >= 2; k--) begin
            nxt_valid[k] = sb_valid[k-1];
            nxt_load[k]  = sb_load[k-1];
            nxt_wa[k]    = sb_wa[k-1];
         end
         nxt_valid[1] = issue_o & writes_rf_i & (wa_i != '0);
         nxt_load[1]  = is_load_i;
         nxt_wa[1]    = wa_i;
      end
      nxt_inflight = '0;
      for (int k = 1; k <= D; k++) begin
         nxt_inflight = nxt_inflight + IW'(nxt_valid[k]);
      end
   end

   // Legacy counter: 1 on issue, then steps through the bubble slots and wraps to 0.
   always_comb begin
      nxt_cnt = cnt;
      if (flush_i) begin
         nxt_cnt = '0;
      end else if (issue_o) begin
         nxt_cnt = FIXED ? CW'(1) : '0;
      end else if (cnt != '0) begin
         nxt_cnt = (cnt == CW'(FIXED_NOP_P)) ? '0 : cnt + CW'(1);
      end
   end

   always_comb begin
      nxt_nop = nop_count_o;
      if (bubble_o && !flush_i && (nop_count_o != 32'hFFFF_FFFF)) begin
         nxt_nop = nop_count_o + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sb_valid       <= '0;
         sb_load        <= '0;
         for (int k = 1; k <= D; k++) begin
            sb_wa[k] <= '0;
         end
         cnt            <= '0;
         inflight_cnt_o <= '0;
         nop_count_o    <= '0;
      end else if (!hold_i) begin
         sb_valid       <= nxt_valid;
         sb_load        <= nxt_load;
         for (int k = 1; k <= D; k++) begin
            sb_wa[k] <= nxt_wa[k];
         end
         cnt            <= nxt_cnt;
         inflight_cnt_o <= nxt_inflight;
         nop_count_o    <= nxt_nop;
      end
   end

   a_issue_excl: assert property (@(posedge clk) disable iff (reset) !(issue_o && bubble_o));
   a_cnt_range:  assert property (@(posedge clk) disable iff (reset) cnt <= CW'(FIXED_NOP_P));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// Bench for pipe_hazard_ctrl: five configurations share one stimulus stream and are
// checked against an instruction-list reference model through an expected queue.
module tb_pipe_hazard_ctrl;

   localparam int NCFG = 5;

   function automatic int cfg_s(input int c);
      return (c < 2) ? 3 : 5;
   endfunction
   function automatic int cfg_b(input int c);
      return (c == 1 || c == 3) ? 1 : 0;
   endfunction
   function automatic int cfg_f(input int c);
      return (c == 4) ? 2 : 0;
   endfunction

   typedef struct packed {
      logic       w;
      logic [5:0] wa;
      logic       ld;
   } rec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       issue_valid, rs_used, rd_used, writes_rf, is_load, hold, flush;
   logic [5:0] rs_addr, rd_addr, wa;

   logic [NCFG-1:0]       act_bubble, act_issue, act_fwd_rs, act_fwd_rd;
   logic [NCFG-1:0][2:0]  act_infl;
   logic [NCFG-1:0][31:0] act_nop;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NCFG; g++) begin : g_dut
      localparam int S = cfg_s(g);
      logic [$clog2(S)-1:0] infl;
      pipe_hazard_ctrl #(
         .STAGES_P(S), .RF_ADDR_W_P(6), .BYPASS_P(cfg_b(g)), .FIXED_NOP_P(cfg_f(g))
      ) u_dut (
         .clk(clk), .reset(reset), .issue_valid_i(issue_valid),
         .rs_addr_i(rs_addr), .rd_addr_i(rd_addr), .rs_used_i(rs_used), .rd_used_i(rd_used),
         .writes_rf_i(writes_rf), .wa_i(wa), .is_load_i(is_load), .hold_i(hold), .flush_i(flush),
         .bubble_o(act_bubble[g]), .issue_o(act_issue[g]), .fwd_rs_o(act_fwd_rs[g]),
         .fwd_rd_o(act_fwd_rd[g]), .inflight_cnt_o(infl), .nop_count_o(act_nop[g])
      );
      assign act_infl[g] = 3'(infl);
   end

   // Reference model: list of in-flight instructions, youngest first.
   rec_t        flight [NCFG][$];
   int          rem [NCFG];
   logic [31:0] nopc [NCFG];
   logic [38:0] exp_q [$];
   int          checks   = 0;
   int          failures = 0;

   function automatic int youngest(input int c, input logic used, input logic [5:0] a);
      if (!used) return 0;
      for (int i = 0; i < flight[c].size(); i++) begin
         if (flight[c][i].w && flight[c][i].wa == a) return i + 1;
      end
      return 0;
   endfunction

   task automatic model_cycle(input int c);
      int   d, fx, age_rs, age_rd, inf;
      bit   byp, ld_rs, ld_rd, st_rs, st_rd, e_bub, e_iss, e_frs, e_frd;
      rec_t r;
      d   = cfg_s(c) - 2;
      byp = (cfg_b(c) != 0);
      fx  = cfg_f(c);
      if (reset) begin
         flight[c].delete();
         rem[c]  = 0;
         nopc[c] = '0;
      end
      age_rs = youngest(c, rs_used, rs_addr);
      age_rd = youngest(c, rd_used, rd_addr);
      ld_rs  = (age_rs != 0) && flight[c][age_rs-1].ld;
      ld_rd  = (age_rd != 0) && flight[c][age_rd-1].ld;
      if (fx > 0) begin
         e_bub = (rem[c] > 0);
         e_frs = 1'b0;
         e_frd = 1'b0;
      end else begin
         st_rs = (age_rs != 0) && (age_rs < d || !byp || ld_rs);
         st_rd = (age_rd != 0) && (age_rd < d || !byp || ld_rd);
         e_frs = byp && (age_rs == d) && !ld_rs;
         e_frd = byp && (age_rd == d) && !ld_rd;
         e_bub = issue_valid && (st_rs || st_rd);
      end
      e_iss = issue_valid && !e_bub && !hold && !flush;
      inf = 0;
      for (int i = 0; i < flight[c].size(); i++) inf += int'(flight[c][i].w);
      exp_q.push_back({e_bub, e_iss, e_frs, e_frd, 3'(inf), nopc[c]});
      if (!reset && !hold) begin
         if (e_bub && !flush && nopc[c] != 32'hFFFF_FFFF) nopc[c] = nopc[c] + 1;
         if (flush) begin
            flight[c].delete();
            rem[c] = 0;
         end else begin
            r.w  = writes_rf && (wa != 0);
            r.wa = wa;
            r.ld = is_load;
            if (!e_iss) r = '0;
            flight[c].push_front(r);
            if (flight[c].size() > d) void'(flight[c].pop_back());
            if (e_iss) rem[c] = fx;
            else if (rem[c] > 0) rem[c] = rem[c] - 1;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic drive(input logic iv, input logic [5:0] rs, input logic rsu,
                        input logic [5:0] rd, input logic rdu, input logic wr,
                        input logic [5:0] w, input logic ld, input logic hd,
                        input logic fl, input logic rst);
      @(posedge clk);
      #1;
      issue_valid = iv;  rs_addr = rs;  rs_used = rsu;  rd_addr = rd;  rd_used = rdu;
      writes_rf   = wr;  wa      = w;   is_load = ld;   hold    = hd;  flush   = fl;
      reset       = rst;
      for (int c = 0; c < NCFG; c++) model_cycle(c);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   // Monitor: outputs are presented every cycle; compare each configuration's outputs.
   initial begin
      logic [38:0] e, a;
      forever begin
         @(negedge clk);
         for (int c = 0; c < NCFG; c++) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               a = {act_bubble[c], act_issue[c], act_fwd_rs[c], act_fwd_rd[c], act_infl[c], act_nop[c]};
               checks++;
               if (a !== e) begin
                  failures++;
                  $display("FAIL sb_cfg%0d @%0t bubble/issue/fwd_rs/fwd_rd/infl/nop got %b %b %b %b %0d %0d expected %b %b %b %b %0d %0d",
                           c, $time, a[38], a[37], a[36], a[35], a[34:32], a[31:0],
                           e[38], e[37], e[36], e[35], e[34:32], e[31:0]);
               end
            end
         end
      end
   end

   initial begin
      bit [0:9] pat;
      logic     iv, rsu, rdu, wr, ld, hd, fl, rst, fl_prev, hd_prev;
      logic [5:0] rs, rd, w;
      issue_valid = 0; rs_addr = 0; rd_addr = 0; rs_used = 0; rd_used = 0;
      writes_rf = 0; wa = 0; is_load = 0; hold = 0; flush = 0; reset = 1;

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      sample();
      chk("rst_nop", act_nop[2], 0);
      chk("rst_infl", act_infl[2], 0);
      idle(1);

      // ADD r3 then reader of r3
      drive(1, 6'd1, 1, 6'd2, 0, 1, 6'd3, 0, 0, 0, 0);
      sample();
      chk("t1_wr_issue_s3", act_issue[0], 1);
      drive(1, 6'd3, 1, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0);
      sample();
      chk("t1_bubble_s3", act_bubble[0], 1);
      chk("t1_fwd_rs_byp", act_fwd_rs[1], 1);
      chk("t1_issue_byp", act_issue[1], 1);
      chk("t1_bubble_s5", act_bubble[2], 1);
      chk("t1_infl_s5_a", act_infl[2], 1);
      drive(1, 6'd3, 1, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0);
      sample();
      chk("t1_issue_s3", act_issue[0], 1);
      chk("t1_infl_s5_b", act_infl[2], 1);
      drive(1, 6'd3, 1, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0);
      sample();
      chk("t1_infl_s5_c", act_infl[2], 1);
      chk("t1_bubble_s5_3rd", act_bubble[2], 1);
      drive(1, 6'd3, 1, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0);
      sample();
      chk("t1_issue_s5", act_issue[2], 1);
      chk("t1_infl_s5_d", act_infl[2], 0);
      chk("t1_nop_s5", act_nop[2], 3);
      chk("t1_nop_s3", act_nop[0], 1);
      chk("t1_nop_byp", act_nop[1], 0);

      // load-use cannot be bypassed; ALU result can feed both sources
      idle(4);
      drive(1, 0, 0, 0, 0, 1, 6'd3, 1, 0, 0, 0);
      drive(1, 6'd3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      sample();
      chk("t2_ld_bubble_byp", act_bubble[1], 1);
      chk("t2_ld_fwd_byp", act_fwd_rs[1], 0);
      drive(1, 6'd3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      sample();
      chk("t2_ld_issue_byp", act_issue[1], 1);
      idle(4);
      drive(1, 0, 0, 0, 0, 1, 6'd7, 0, 0, 0, 0);
      drive(1, 6'd7, 1, 6'd7, 1, 0, 0, 0, 0, 0, 0);
      sample();
      chk("t2_fwd_rs_both", act_fwd_rs[1], 1);
      chk("t2_fwd_rd_both", act_fwd_rd[1], 1);
      chk("t2_bubble_rd_s3", act_bubble[0], 1);

      // r0 never hazards
      idle(4);
      drive(1, 0, 0, 0, 0, 1, 6'd0, 0, 0, 0, 0);
      drive(1, 6'd0, 1, 6'd0, 1, 0, 0, 0, 0, 0, 0);
      sample();
      chk("t3_r0_bubble_s5", act_bubble[2], 0);
      chk("t3_r0_issue_s5", act_issue[2], 1);

      // flush with the branch in the RF-writing stage empties the scoreboard
      idle(4);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 6'd4, 0, 0, 0, 0);
      drive(1, 6'd4, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      sample();
      chk("t4_flush_issue_s5", act_issue[2], 0);
      drive(1, 6'd4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      sample();
      chk("t4_post_issue_s5", act_issue[2], 1);
      chk("t4_post_bubble_s5", act_bubble[2], 0);
      chk("t4_post_infl_s5", act_infl[2], 0);

      // legacy fixed-nop pattern with a 3-cycle hold mid-pattern
      idle(4);
      pat = 10'b1001000001;
      for (int i = 0; i < 10; i++) begin
         drive(1, 6'd1, 1, 6'd2, 1, 0, 0, 0, (i >= 4 && i <= 6), 0, 0);
         sample();
         chk($sformatf("t5_fixed_issue%0d", i), act_issue[4], 32'(pat[i]));
      end

      // async reset while a bubble is being inserted
      idle(4);
      drive(1, 0, 0, 0, 0, 1, 6'd5, 0, 0, 0, 0);
      drive(1, 6'd5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      sample();
      chk("t6_bubble_before", act_bubble[2], 1);
      #2 reset = 1'b1;
      #1;
      chk("t6_bubble_in_rst", act_bubble[2], 0);
      chk("t6_nop_in_rst", act_nop[2], 0);
      chk("t6_infl_in_rst", act_infl[2], 0);
      drive(1, 6'd5, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 6'd5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      sample();
      chk("t6_issue_after", act_issue[2], 1);

      // random traffic; a flush blocked by hold is held until hold drops
      fl_prev = 0;
      hd_prev = 0;
      for (int n = 0; n < 1500; n++) begin
         iv  = ($urandom_range(0, 3) != 0);
         rs  = 6'($urandom_range(0, 4));
         rd  = 6'($urandom_range(0, 4));
         w   = 6'($urandom_range(0, 4));
         rsu = 1'($urandom_range(0, 1));
         rdu = 1'($urandom_range(0, 1));
         wr  = 1'($urandom_range(0, 1));
         ld  = ($urandom_range(0, 3) == 0);
         hd  = ($urandom_range(0, 7) == 0);
         fl  = ($urandom_range(0, 11) == 0) || (fl_prev && hd_prev);
         rst = ($urandom_range(0, 149) == 0);
         drive(iv, rs, rsu, rd, rdu, wr, w, ld, hd, fl, rst);
         fl_prev = fl;
         hd_prev = hd;
      end

      idle(1);
      sample();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
